pong_match_ctrl: RTL and testbench

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

---
 rtl/pong_match_ctrl.sv | 129 ++++++++++++
 tb/tb_pong_match_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: start/serve/rally/point/game-over flow, score keeping
// and the ball-step tick divider that only runs during a rally.
module pong_match_ctrl #(
  parameter int WIN_SCORE = 7,
  parameter int TICK_DIV  = 12500000
) (
  input  logic       clk,
  input  logic       ireset,
  input  logic       istart,
  input  logic       iserved,
  input  logic       lpoint,
  input  logic       rpoint,
  output logic       lsrv_en,
  output logic       rsrv_en,
  output logic       tick,
  output logic [3:0] lscore,
  output logic [3:0] rscore,
  output logic       lwin,
  output logic       rwin,
  output logic [2:0] mstate
);

  localparam int              CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [3:0]      WIN       = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    M_IDLE  = 3'd0,
    M_SRVL  = 3'd1,
    M_SRVR  = 3'd2,
    M_RALLY = 3'd3,
    M_POINT = 3'd4,
    M_OVER  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    lscore_q, lscore_d;
  logic [3:0]    rscore_q, rscore_d;
  logic          lwin_q, lwin_d;
  logic          rwin_q, rwin_d;
  logic          last_left_q, last_left_d;
  logic          start_q;
  logic          start_ev;

  // Button is active low: an event is the high-to-low transition only.
  assign start_ev = start_q & ~istart;

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    lscore_d    = lscore_q;
    rscore_d    = rscore_q;
    lwin_d      = lwin_q;
    rwin_d      = rwin_q;
    last_left_d = last_left_q;
    case (state_q)
      M_IDLE, M_OVER: begin
        if (start_ev) begin
          lscore_d = '0;
          rscore_d = '0;
          lwin_d   = 1'b0;
          rwin_d   = 1'b0;
          state_d  = M_SRVL;
        end
      end
      M_SRVL, M_SRVR: begin
        if (iserved) state_d = M_RALLY;
      end
      M_RALLY: begin
        cnt_d = (cnt_q == TICK_LAST) ? '0 : cnt_q + CW'(1);
        if (lpoint) begin
          if (lscore_q < WIN) lscore_d = lscore_q + 4'd1;
          last_left_d = 1'b1;
          state_d     = M_POINT;
        end else if (rpoint) begin
          if (rscore_q < WIN) rscore_d = rscore_q + 4'd1;
          last_left_d = 1'b0;
          state_d     = M_POINT;
        end
      end
      M_POINT: begin
        if (lscore_q == WIN) begin
          lwin_d  = 1'b1;
          state_d = M_OVER;
        end else if (rscore_q == WIN) begin
          rwin_d  = 1'b1;
          state_d = M_OVER;
        end else begin
          // The player who was just scored on gets the serve.
          state_d = last_left_q ? M_SRVR : M_SRVL;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ireset) begin
      state_q     <= M_IDLE;
      cnt_q       <= '0;
      lscore_q    <= '0;
      rscore_q    <= '0;
      lwin_q      <= 1'b0;
      rwin_q      <= 1'b0;
      last_left_q <= 1'b0;
      start_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lscore_q    <= lscore_d;
      rscore_q    <= rscore_d;
      lwin_q      <= lwin_d;
      rwin_q      <= rwin_d;
      last_left_q <= last_left_d;
      start_q     <= istart;
    end
  end

  assign lsrv_en = (state_q == M_SRVL);
  assign rsrv_en = (state_q == M_SRVR);
  assign tick    = (state_q == M_RALLY) && (cnt_q == TICK_LAST);
  assign lscore  = lscore_q;
  assign rscore  = rscore_q;
  assign lwin    = lwin_q;
  assign rwin    = rwin_q;
  assign mstate  = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed vector table, hand sequences for match
// end and reset mid-rally, then random stimulus against a behavioural model.
module tb_pong_match_ctrl;

  localparam int TD = 4;
  localparam int WS = 3;

  logic       clk = 1'b0;
  logic       ireset, istart, iserved, lpoint, rpoint;
  logic       lsrv_en, rsrv_en, tick, lwin, rwin;
  logic [3:0] lscore, rscore;
  logic [2:0] mstate;

  int n_checks = 0;
  int n_pass   = 0;

  pong_match_ctrl #(.WIN_SCORE(WS), .TICK_DIV(TD)) dut (
    .clk(clk), .ireset(ireset), .istart(istart), .iserved(iserved),
    .lpoint(lpoint), .rpoint(rpoint), .lsrv_en(lsrv_en), .rsrv_en(rsrv_en),
    .tick(tick), .lscore(lscore), .rscore(rscore), .lwin(lwin), .rwin(rwin),
    .mstate(mstate)
  );

  always #5 clk = ~clk;

  logic [15:0] dut_out;
  assign dut_out = {mstate, lscore, rscore, lwin, rwin, lsrv_en, rsrv_en, tick};

  // Behavioural model: match phase as a number, scores as integers,
  // and a count of cycles spent in the current rally.
  int m_st = 0, m_ls = 0, m_rs = 0, m_rc = 0;
  bit m_lw = 0, m_rw = 0, m_prev = 1, m_lastl = 0;

  task automatic model_step(input bit ir, st, sv, lp, rp);
    bit ev;
    ev = m_prev && !st;
    if (ir) begin
      m_st = 0; m_ls = 0; m_rs = 0; m_lw = 0; m_rw = 0; m_rc = 0; m_prev = 1;
      return;
    end
    m_prev = st;
    case (m_st)
      0, 5: if (ev) begin
        m_ls = 0; m_rs = 0; m_lw = 0; m_rw = 0; m_st = 1;
      end
      1, 2: if (sv) begin m_st = 3; m_rc = 0; end
      3: begin
        m_rc++;
        if (lp) begin
          m_ls = (m_ls < WS) ? m_ls + 1 : m_ls; m_lastl = 1; m_st = 4;
        end else if (rp) begin
          m_rs = (m_rs < WS) ? m_rs + 1 : m_rs; m_lastl = 0; m_st = 4;
        end
      end
      4: begin
        if (m_ls == WS)      begin m_lw = 1; m_st = 5; end
        else if (m_rs == WS) begin m_rw = 1; m_st = 5; end
        else m_st = m_lastl ? 2 : 1;
      end
      default: m_st = 0;
    endcase
  endtask

  function automatic logic [15:0] model_out();
    bit t;
    t = (m_st == 3) && ((m_rc % TD) == TD - 1);
    return {3'(m_st), 4'(m_ls), 4'(m_rs), m_lw, m_rw,
            (m_st == 1), (m_st == 2), t};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got ms/ls/rs/lw/rw/lsrv/rsrv/tick=%h required %h (t=%0t)",
                  name, act, exp, $time);
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit ir, st, sv, lp, rp);
    ireset = ir; istart = st; iserved = sv; lpoint = lp; rpoint = rp;
    model_step(ir, st, sv, lp, rp);
    @(posedge clk);
    #1;
    check("model", dut_out, model_out());
  endtask

  function automatic logic [15:0] pk(int ms, int ls, int rs, bit lw, bit rw,
                                     bit ls_en, bit rs_en, bit t);
    return {3'(ms), 4'(ls), 4'(rs), lw, rw, ls_en, rs_en, t};
  endfunction

  typedef struct {
    bit          ir, st, sv, lp, rp;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[28];

  initial begin
    // reset, then start button held low
    vecs[0] = '{1, 1, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    for (int i = 1; i <= 9; i++)
      vecs[i] = '{0, 0, 0, (i == 5), (i == 5), pk(1, 0, 0, 0, 0, 1, 0, 0)};
    // serve, then a quiet rally: tick every 4th cycle
    vecs[10] = '{0, 1, 1, 0, 0, pk(3, 0, 0, 0, 0, 0, 0, 0)};
    for (int i = 11; i <= 21; i++)
      vecs[i] = '{0, 1, 0, 0, 0, pk(3, 0, 0, 0, 0, 0, 0, ((i - 10) % TD) == TD - 1)};
    vecs[22] = '{0, 1, 0, 1, 0, pk(4, 1, 0, 0, 0, 0, 0, 0)};
    vecs[23] = '{0, 1, 0, 0, 0, pk(2, 1, 0, 0, 0, 0, 1, 0)};
    vecs[24] = '{0, 1, 1, 0, 0, pk(3, 1, 0, 0, 0, 0, 0, 0)};
    vecs[25] = '{0, 1, 0, 1, 1, pk(4, 2, 0, 0, 0, 0, 0, 0)};
    vecs[26] = '{0, 1, 0, 0, 0, pk(2, 2, 0, 0, 0, 0, 1, 0)};
    vecs[27] = '{0, 1, 0, 1, 1, pk(2, 2, 0, 0, 0, 0, 1, 0)};

    ireset = 1; istart = 1; iserved = 0; lpoint = 0; rpoint = 0;
    for (int i = 0; i < 28; i++) begin
      step(vecs[i].ir, vecs[i].st, vecs[i].sv, vecs[i].lp, vecs[i].rp);
      check($sformatf("vec%0d", i), dut_out, vecs[i].exp);
    end

    // match end: three right points from ls=2, rs=0
    for (int p = 1; p <= 3; p++) begin
      step(0, 1, 1, 0, 0);
      step(0, 1, 0, 0, 1);
      check($sformatf("rpoint%0d", p), dut_out, pk(4, 2, p, 0, 0, 0, 0, 0));
      step(0, 1, 0, 0, 0);
    end
    check("over", dut_out, pk(5, 2, 3, 0, 1, 0, 0, 0));
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 1, 1);
    check("over_hold", dut_out, pk(5, 2, 3, 0, 1, 0, 0, 0));
    step(0, 0, 0, 0, 0);
    check("restart", dut_out, pk(1, 0, 0, 0, 0, 1, 0, 0));

    // reset mid-rally at ls=2, rs=1
    step(0, 1, 1, 0, 0); step(0, 1, 0, 1, 0); step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0); step(0, 1, 0, 1, 0); step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0); step(0, 1, 0, 0, 1); step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
    check("pre_reset", dut_out, pk(3, 2, 1, 0, 0, 0, 0, 0));
    step(1, 1, 0, 0, 0);
    check("reset_rally", dut_out, pk(0, 0, 0, 0, 0, 0, 0, 0));
    step(0, 1, 1, 1, 1);
    step(0, 1, 0, 1, 0);
    check("idle_stray", dut_out, pk(0, 0, 0, 0, 0, 0, 0, 0));

    // random play against the model
    for (int i = 0; i < 4000; i++)
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
